// File: rtl/game_pkg.sv
// Shared types and constants for the game-phase sequencer and the VGA objects mux.
package game_pkg;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned NUM_LAYERS = 6;

    // Layer-enable bit positions
    localparam int unsigned LAYER_SCORE    = 0;
    localparam int unsigned LAYER_TIMER    = 1;
    localparam int unsigned LAYER_MONSTERS = 2;
    localparam int unsigned LAYER_PACMAN   = 3;
    localparam int unsigned LAYER_WALLS    = 4;
    localparam int unsigned LAYER_COINS    = 5;

    localparam logic [NUM_LAYERS-1:0] ALL_LAYERS = '1;

    // Game phases; the encoding is exported on gameState for debug
    typedef enum logic [2:0] {
        ST_OPENING = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_END     = 3'd4
    } game_state_t;

    // Drawing priority in the objects mux, highest first
    typedef enum logic [2:0] {
        MUX_OPENING  = 3'd0,
        MUX_ENDING   = 3'd1,
        MUX_SCORE    = 3'd2,
        MUX_TIMER    = 3'd3,
        MUX_MONSTERS = 3'd4,
        MUX_PACMAN   = 3'd5,
        MUX_WALLS    = 3'd6,
        MUX_COINS    = 3'd7
    } mux_prio_t;

    // Layer enable mask for a given phase; pac_on selects the READY blink phase
    function automatic logic [NUM_LAYERS-1:0] layer_mask(input game_state_t s, input logic pac_on);
        logic [NUM_LAYERS-1:0] m;
        m = '0;
        case (s)
            ST_READY: begin
                m               = ALL_LAYERS;
                m[LAYER_PACMAN] = pac_on;
            end
            ST_PLAY, ST_PAUSE: m = ALL_LAYERS;
            default:           m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_latch.sv
// Optional rising-edge detector feeding a sticky flag that is cleared by i_clr.
// o_pending_c also shows a set arriving in the same cycle as the clear.
module edge_latch #(
    parameter bit USE_EDGE = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_in,
    input  logic i_clr,
    output logic o_pending_c
);

    logic r_prev;
    logic r_flag;
    logic w_set;

    assign w_set       = USE_EDGE ? (i_in & ~r_prev) : i_in;
    assign o_pending_c = r_flag | w_set;

    // Previous input sample for edge detection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_prev <= 1'b0;
        else         r_prev <= i_in;
    end

    // Sticky flag: clear wins, since a same-cycle set is consumed through o_pending_c
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)    r_flag <= 1'b0;
        else if (i_clr) r_flag <= 1'b0;
        else if (w_set) r_flag <= 1'b1;
    end

endmodule

// File: rtl/game_screen_controller.sv
// Frame-synchronous game-phase sequencer driving screen requests and layer enables.
module game_screen_controller
    import game_pkg::*;
#(
    parameter int unsigned OPEN_MIN_FRAMES = 30,
    parameter int unsigned READY_FRAMES    = 120,
    parameter int unsigned END_HOLD_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES    = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  startKey,
    input  logic                  pauseKey,
    input  logic                  pacmanDied,
    input  logic                  timeUp,
    input  logic                  allCoinsEaten,
    output logic                  openingScreenEn,
    output logic                  endingScreenEn,
    output logic [NUM_LAYERS-1:0] layerEn,
    output logic                  gameRunning,
    output logic                  gameWon,
    output logic                  newGamePulse,
    output logic [2:0]            gameState
);

    game_state_t      r_state;
    game_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_next_won;
    logic             w_new_game;
    logic             w_blink_on;
    logic             w_start;
    logic             w_pause;
    logic             w_died;
    logic             w_timeup;
    logic             w_coins;

    edge_latch #(.USE_EDGE(1'b1)) u_start  (.clk(clk), .resetN(resetN), .i_in(startKey),      .i_clr(startOfFrame), .o_pending_c(w_start));
    edge_latch #(.USE_EDGE(1'b1)) u_pause  (.clk(clk), .resetN(resetN), .i_in(pauseKey),      .i_clr(startOfFrame), .o_pending_c(w_pause));
    edge_latch #(.USE_EDGE(1'b0)) u_died   (.clk(clk), .resetN(resetN), .i_in(pacmanDied),    .i_clr(startOfFrame), .o_pending_c(w_died));
    edge_latch #(.USE_EDGE(1'b0)) u_timeup (.clk(clk), .resetN(resetN), .i_in(timeUp),        .i_clr(startOfFrame), .o_pending_c(w_timeup));
    edge_latch #(.USE_EDGE(1'b0)) u_coins  (.clk(clk), .resetN(resetN), .i_in(allCoinsEaten), .i_clr(startOfFrame), .o_pending_c(w_coins));

    // Next phase, win flag and new-game strobe, evaluated only on the frame boundary
    always_comb begin
        w_next_state = r_state;
        w_next_won   = gameWon;
        w_new_game   = 1'b0;
        if (startOfFrame) begin
            case (r_state)
                ST_OPENING: begin
                    if (w_start && (r_cnt >= CNT_W'(OPEN_MIN_FRAMES))) begin
                        w_next_state = ST_READY;
                        w_new_game   = 1'b1;
                        w_next_won   = 1'b0;
                    end
                end
                ST_READY: begin
                    if (r_cnt == CNT_W'(READY_FRAMES - 1)) w_next_state = ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_died || w_timeup) begin
                        w_next_state = ST_END;
                        w_next_won   = 1'b0;
                    end else if (w_coins) begin
                        w_next_state = ST_END;
                        w_next_won   = 1'b1;
                    end else if (w_pause) begin
                        w_next_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause) w_next_state = ST_PLAY;
                end
                ST_END: begin
                    if (w_start && (r_cnt >= CNT_W'(END_HOLD_FRAMES))) w_next_state = ST_OPENING;
                end
                default: w_next_state = ST_OPENING;
            endcase
        end
    end

    // Frame counter: cleared on a phase change, otherwise saturating count of frames
    always_comb begin
        w_next_cnt = r_cnt;
        if (startOfFrame) begin
            if (w_next_state != r_state) w_next_cnt = '0;
            else if (r_cnt != '1)        w_next_cnt = r_cnt + CNT_W'(1);
        end
    end

    assign w_blink_on = ((32'(w_next_cnt) / BLINK_FRAMES) % 32'd2) == 32'd0;

    // Phase register and registered outputs decoded from the upcoming phase
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state         <= ST_OPENING;
            r_cnt           <= '0;
            openingScreenEn <= 1'b1;
            endingScreenEn  <= 1'b0;
            layerEn         <= '0;
            gameRunning     <= 1'b0;
            gameWon         <= 1'b0;
            newGamePulse    <= 1'b0;
            gameState       <= ST_OPENING;
        end else begin
            r_state         <= w_next_state;
            r_cnt           <= w_next_cnt;
            openingScreenEn <= (w_next_state == ST_OPENING);
            endingScreenEn  <= (w_next_state == ST_END);
            layerEn         <= layer_mask(w_next_state, w_blink_on);
            gameRunning     <= (w_next_state == ST_PLAY);
            gameWon         <= w_next_won;
            newGamePulse    <= w_new_game;
            gameState       <= w_next_state;
        end
    end

endmodule
